// File: rtl/perm_rank_seq.sv
// Sequential permutation ranker/unranker: converts between a K-element
// permutation and its lexicographic (Lehmer) index, one position per cycle.
module perm_rank_seq #(
    parameter int K  = 4,
    parameter int W  = (K > 1) ? $clog2(K) : 1,
    parameter int RW = (K <= 2) ? 1 : (K == 3) ? 3 : (K == 4) ? 5 : (K == 5) ? 7 :
                       (K == 6) ? 10 : (K == 7) ? 13 : 16
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic            in_mode,
    input  logic [K*W-1:0]  in_perm,
    input  logic [RW-1:0]   in_rank,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [K*W-1:0]  out_perm,
    output logic [RW-1:0]   out_rank,
    output logic            out_err
);

    localparam int XW = RW + W;

    typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

    function automatic logic [XW-1:0] fact(input int unsigned n);
        logic [XW-1:0] f;
        f = XW'(1);
        for (int unsigned i = 2; i <= n; i++) begin
            f = f * XW'(i);
        end
        return f;
    endfunction

    localparam logic [XW-1:0] FACT_K = fact(K);

    logic [XW-1:0] fact_tab [K];
    for (genvar g = 0; g < K; g++) begin : g_fact
        assign fact_tab[g] = fact(g);
    end

    state_t          state_q;
    logic            mode_q;
    logic [K*W-1:0]  perm_q;
    logic [K-1:0]    used_q;
    logic [XW-1:0]   acc_q;
    logic [XW-1:0]   rem_q;
    logic [W-1:0]    cnt_q;
    logic            err_q;
    logic [K*W-1:0]  out_perm_q;
    logic [RW-1:0]   out_rank_q;
    logic            out_err_q;

    logic [W-1:0]    p_cur;
    logic [W-1:0]    limit;
    logic [XW-1:0]   f_cur;
    logic [XW-1:0]   lt_cnt;
    logic            elem_bad;
    logic [K-1:0]    used_rank_d;
    logic [K-1:0]    used_unrank_d;
    logic [K-1:0]    used_d;
    logic [W-1:0]    digit;
    logic [W-1:0]    seen;
    logic [W-1:0]    sel;
    logic [XW-1:0]   acc_d;
    logic [XW-1:0]   rem_d;
    logic [K*W-1:0]  perm_d;
    logic            err_d;
    logic            rank_big;

    assign rank_big = ({{W{1'b0}}, in_rank} >= FACT_K);

    always_comb begin
        p_cur         = perm_q[cnt_q*W +: W];
        limit         = W'(K - 1) - cnt_q;
        f_cur         = fact_tab[limit];
        lt_cnt        = '0;
        elem_bad      = ({1'b0, p_cur} >= (W+1)'(K));
        used_rank_d   = used_q;
        digit         = '0;
        seen          = '0;
        sel           = '0;
        // Rank step: count smaller unused values, flag out-of-range or reused elements.
        for (int unsigned v = 0; v < K; v++) begin
            if (!used_q[v] && (W'(v) < p_cur)) begin
                lt_cnt = lt_cnt + XW'(1);
            end
            if (W'(v) == p_cur) begin
                if (used_q[v]) begin
                    elem_bad = 1'b1;
                end
                used_rank_d[v] = 1'b1;
            end
        end
        // Unrank step: largest digit with digit*f <= remainder, via parallel compares.
        for (int unsigned j = 0; j < K; j++) begin
            if ((W'(j) <= limit) && ((XW'(j) * f_cur) <= rem_q)) begin
                digit = W'(j);
            end
        end
        for (int unsigned v = 0; v < K; v++) begin
            if (!used_q[v]) begin
                if (seen == digit) begin
                    sel = W'(v);
                end
                seen = seen + W'(1);
            end
        end
        used_unrank_d      = used_q;
        used_unrank_d[sel] = 1'b1;
        used_d = mode_q ? used_unrank_d : used_rank_d;
        acc_d  = acc_q * (XW'(K) - XW'(cnt_q)) + lt_cnt;
        rem_d  = rem_q - XW'(digit) * f_cur;
        perm_d = perm_q;
        perm_d[cnt_q*W +: W] = sel;
        err_d  = err_q | (!mode_q & elem_bad);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= IDLE;
            mode_q     <= 1'b0;
            perm_q     <= '0;
            used_q     <= '0;
            acc_q      <= '0;
            rem_q      <= '0;
            cnt_q      <= '0;
            err_q      <= 1'b0;
            out_perm_q <= '0;
            out_rank_q <= '0;
            out_err_q  <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (in_valid) begin
                        state_q <= BUSY;
                        mode_q  <= in_mode;
                        perm_q  <= in_mode ? '0 : in_perm;
                        rem_q   <= XW'(in_rank);
                        acc_q   <= '0;
                        used_q  <= '0;
                        cnt_q   <= '0;
                        err_q   <= in_mode & rank_big;
                    end
                end
                BUSY: begin
                    used_q <= used_d;
                    cnt_q  <= cnt_q + W'(1);
                    err_q  <= err_d;
                    if (mode_q) begin
                        perm_q <= perm_d;
                        rem_q  <= rem_d;
                    end else begin
                        acc_q  <= acc_d;
                    end
                    if (cnt_q == W'(K - 1)) begin
                        state_q    <= DONE;
                        out_err_q  <= err_d;
                        out_rank_q <= (!mode_q && !err_d) ? acc_d[RW-1:0] : '0;
                        out_perm_q <= (mode_q && !err_d) ? perm_d : '0;
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        state_q    <= IDLE;
                        out_perm_q <= '0;
                        out_rank_q <= '0;
                        out_err_q  <= 1'b0;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign in_ready  = (state_q == IDLE);
    assign out_valid = (state_q == DONE);
    assign out_perm  = out_perm_q;
    assign out_rank  = out_rank_q;
    assign out_err   = out_err_q;

endmodule

// File: tb/tb_perm_rank_seq.sv
// Randomized self-checking bench for perm_rank_seq (K=4) against a
// factorial-number-system reference model.
module tb_perm_rank_seq;

    localparam int K  = 4;
    localparam int W  = 2;
    localparam int RW = 5;

    logic            clk = 1'b0;
    logic            rst;
    logic            in_valid;
    logic            in_ready;
    logic            in_mode;
    logic [K*W-1:0]  in_perm;
    logic [RW-1:0]   in_rank;
    logic            out_valid;
    logic            out_ready;
    logic [K*W-1:0]  out_perm;
    logic [RW-1:0]   out_rank;
    logic            out_err;

    int n_checks = 0;
    int n_pass   = 0;

    always #5 clk = ~clk;

    perm_rank_seq #(.K(K)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_mode   (in_mode),
        .in_perm   (in_perm),
        .in_rank   (in_rank),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_perm  (out_perm),
        .out_rank  (out_rank),
        .out_err   (out_err)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    endtask

    function automatic int fact(input int n);
        int f = 1;
        for (int i = 2; i <= n; i++) f = f * i;
        return f;
    endfunction

    // Rank = sum over positions of (later elements smaller than this one) * (remaining)!
    function automatic void model_rank(input logic [7:0] p, output int r, output bit err);
        int e [4];
        for (int i = 0; i < K; i++) e[i] = int'(p[i*W +: W]);
        err = 1'b0;
        r   = 0;
        for (int i = 0; i < K; i++)
            for (int j = i + 1; j < K; j++)
                if (e[i] == e[j]) err = 1'b1;
        for (int i = 0; i < K; i++) begin
            int c = 0;
            for (int j = i + 1; j < K; j++) if (e[j] < e[i]) c++;
            r += c * fact(K - 1 - i);
        end
        if (err) r = 0;
    endfunction

    function automatic void model_unrank(input int r, output logic [7:0] p, output bit err);
        int avail [$];
        int rr;
        p   = '0;
        err = (r >= fact(K));
        if (err) return;
        avail = {0, 1, 2, 3};
        rr    = r;
        for (int i = 0; i < K; i++) begin
            int f = fact(K - 1 - i);
            int d = rr / f;
            rr = rr % f;
            p[i*W +: W] = 2'(avail[d]);
            avail.delete(d);
        end
    endfunction

    task automatic accept(input bit mode, input logic [7:0] perm, input logic [4:0] rank, input string tag);
        int w = 0;
        @(negedge clk);
        while (!in_ready && w < 20) begin
            @(negedge clk);
            w++;
        end
        if (!in_ready) check({tag, "_ready_timeout"}, 0, 1);
        in_valid = 1'b1;
        in_mode  = mode;
        in_perm  = perm;
        in_rank  = rank;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        in_mode  = 1'($urandom);
        in_perm  = 8'($urandom);
        in_rank  = 5'($urandom);
    endtask

    task automatic wait_valid(input string tag);
        int lat = 0;
        while (!out_valid && lat < 20) begin
            @(posedge clk);
            #1;
            lat++;
        end
        check({tag, "_latency"}, lat, K);
    endtask

    task automatic expect_result(input bit mode, input logic [7:0] perm, input logic [4:0] rank,
                                 input string tag);
        logic [7:0] ep;
        int         er;
        bit         ee;
        if (mode) begin
            model_unrank(int'(rank), ep, ee);
            er = 0;
        end else begin
            model_rank(perm, er, ee);
            ep = '0;
        end
        check({tag, "_perm"}, out_perm, ep);
        check({tag, "_rank"}, out_rank, er);
        check({tag, "_err"},  out_err,  ee);
    endtask

    task automatic release_out(input string tag);
        @(negedge clk);
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        out_ready = 1'b0;
        check({tag, "_idle_after_release"}, {out_valid, in_ready}, 2'b01);
    endtask

    task automatic do_op(input bit mode, input logic [7:0] perm, input logic [4:0] rank, input string tag);
        accept(mode, perm, rank, tag);
        wait_valid(tag);
        expect_result(mode, perm, rank, tag);
        release_out(tag);
    endtask

    initial begin
        logic [7:0] held_perm;
        logic [4:0] held_rank;
        bit         held_err;
        int         seen_valid;

        rst       = 1'b1;
        in_valid  = 1'b0;
        in_mode   = 1'b0;
        in_perm   = '0;
        in_rank   = '0;
        out_ready = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("reset_out_valid", out_valid, 0);
        check("reset_in_ready",  in_ready,  1);
        check("reset_out_perm",  out_perm,  0);
        check("reset_out_rank",  out_rank,  0);
        check("reset_out_err",   out_err,   0);
        @(negedge clk);
        rst = 1'b0;

        do_op(1'b0, 8'hE4, 5'd0,  "rank_identity");
        do_op(1'b0, 8'h1B, 5'd0,  "rank_reverse");
        do_op(1'b0, 8'hB1, 5'd0,  "rank_1032");
        do_op(1'b1, 8'h00, 5'd23, "unrank_23");
        do_op(1'b1, 8'h00, 5'd7,  "unrank_7");
        do_op(1'b0, 8'hE5, 5'd0,  "rank_dup");
        do_op(1'b1, 8'h00, 5'd24, "unrank_24");
        do_op(1'b1, 8'h00, 5'd31, "unrank_31");

        // Unrank every index, then rank the produced permutation back.
        for (int r = 0; r < 24; r++) begin
            logic [7:0] p;
            accept(1'b1, 8'h00, 5'(r), "sweep_unrank");
            wait_valid("sweep_unrank");
            expect_result(1'b1, 8'h00, 5'(r), "sweep_unrank");
            p = out_perm;
            release_out("sweep_unrank");
            accept(1'b0, p, 5'd0, "sweep_rank");
            wait_valid("sweep_rank");
            check("sweep_roundtrip", out_rank, r);
            check("sweep_roundtrip_err", out_err, 0);
            release_out("sweep_rank");
        end

        // Hold out_ready low in DONE while offering a new request.
        accept(1'b0, 8'hB1, 5'd0, "stall");
        wait_valid("stall");
        held_perm = out_perm;
        held_rank = out_rank;
        held_err  = out_err;
        check("stall_rank_value", held_rank, 7);
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            in_valid = 1'b1;
            in_mode  = 1'b1;
            in_rank  = 5'($urandom_range(0, 23));
            @(posedge clk);
            #1;
            check("stall_state", {out_valid, in_ready}, 2'b10);
            check("stall_hold", {out_perm, out_rank, out_err}, {held_perm, held_rank, held_err});
        end
        @(negedge clk);
        in_valid  = 1'b0;
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        out_ready = 1'b0;
        check("stall_release_idle", {out_valid, in_ready}, 2'b01);
        repeat (6) @(posedge clk);
        #1;
        check("stall_no_queued_req", {out_valid, in_ready}, 2'b01);

        // Reset in the second BUSY cycle must abort without a result.
        accept(1'b0, 8'h1B, 5'd0, "abort");
        @(posedge clk);
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        #1;
        check("abort_state", {out_valid, in_ready}, 2'b01);
        check("abort_outputs", {out_perm, out_rank, out_err}, 14'd0);
        @(negedge clk);
        rst = 1'b0;
        seen_valid = 0;
        for (int i = 0; i < 8; i++) begin
            @(posedge clk);
            #1;
            if (out_valid) seen_valid++;
        end
        check("abort_no_result", seen_valid, 0);
        do_op(1'b0, 8'h1B, 5'd0, "after_abort");

        for (int n = 0; n < 40; n++) begin
            bit         m = 1'($urandom);
            logic [7:0] p = 8'($urandom);
            logic [4:0] r = 5'($urandom);
            do_op(m, p, r, "random");
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
